// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg : shared types, defaults and helpers for the regfile_mp block
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_clr_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_clr_ctrl : post-reset clear sequencer, zeroes one entry per cycle
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_clr_ctrl
  import regfile_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = addr_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  output logic          ready_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);

  clr_state_t    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // The counter wraps on the final clear, but the FSM has already left CLEAR.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == CLEAR) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == AW'(DEPTH - 1)) begin
        state_d = READY;
      end
    end
  end

  assign ready_o    = (state_q == READY);
  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = idx_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp : parametrised multi-port register file with post-reset clear.
//              Optional same-cycle write-to-read bypass: REGFILE_BYPASS_EN.
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int NREAD    = 2,
  parameter  int NWRITE   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_width(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  output logic                         ready,
  input  logic [NWRITE-1:0]            we,
  input  logic [NWRITE-1:0][AW-1:0]    wa,
  input  logic [NWRITE-1:0][WIDTH-1:0] wd,
  input  logic [NREAD-1:0][AW-1:0]     ra,
  output logic [NREAD-1:0][WIDTH-1:0]  rd
);

  logic [WIDTH-1:0] rf_q [DEPTH];
  logic             clr_we;
  logic [AW-1:0]    clr_addr;

  regfile_clr_ctrl #(
    .DEPTH (DEPTH)
  ) u_clr_ctrl (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .ready_o    (ready),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // Ascending port order lets the highest-numbered port win a collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      rf_q[clr_addr] <= '0;
    end else begin
      for (int p = 0; p < NWRITE; p++) begin
        if (we[p] && !((ZERO_REG != 0) && (wa[p] == '0))) begin
          rf_q[wa[p]] <= wd[p];
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
      always_comb begin
        rd[i] = '0;
        if (ready && !((ZERO_REG != 0) && (ra[i] == '0))) begin
          rd[i] = rf_q[ra[i]];
`ifdef REGFILE_BYPASS_EN
          for (int p = 0; p < NWRITE; p++) begin
            if (we[p] && (wa[p] == ra[i])) begin
              rd[i] = wd[p];
            end
          end
`endif
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire
